counter_en_sched: RTL and testbench

//  Run-control scheduler for an enabled up-counter. It takes a start/stop command and a latched

---
 rtl/counter_en_sched.sv | 123 ++++++++++++
 tb/tb_counter_en_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_en_sched.sv
// Run-control scheduler: latches a configuration on start, then emits prescaled
// one-cycle enable strobes, mirrors the count and flags terminal count.
module counter_en_sched #(
  parameter int CW = 8,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [CW-1:0] cfg_period,
  input  logic [PW-1:0] cfg_presc,
  input  logic          cfg_reload,
  output logic          en,
  output logic [CW-1:0] cnt,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] presc_cnt_q, presc_cnt_d;
  logic [CW-1:0] period_q, period_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          reload_q, reload_d;
  logic          busy_q, busy_d;
  logic          en_q, en_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [CW-1:0] period_m1;

  // Terminal value computed in CW bits; period_q is never 0 while in RUN.
  assign period_m1 = period_q - CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      presc_cnt_q <= '0;
      period_q    <= '0;
      presc_q     <= '0;
      reload_q    <= 1'b0;
      busy_q      <= 1'b0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      presc_cnt_q <= presc_cnt_d;
      period_q    <= period_d;
      presc_q     <= presc_d;
      reload_q    <= reload_d;
      busy_q      <= busy_d;
      en_q        <= en_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    presc_cnt_d = presc_cnt_q;
    period_d    = period_q;
    presc_d     = presc_q;
    reload_d    = reload_q;
    busy_d      = busy_q;
    en_d        = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (cfg_period != '0) begin
            period_d    = cfg_period;
            presc_d     = cfg_presc;
            reload_d    = cfg_reload;
            cnt_d       = '0;
            presc_cnt_d = '0;
            busy_d      = 1'b1;
            state_d     = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        // stop wins over a strobe falling on the same edge
        if (stop) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (presc_cnt_q != presc_q) begin
          presc_cnt_d = presc_cnt_q + PW'(1);
        end else begin
          presc_cnt_d = '0;
          en_d        = 1'b1;
          if (cnt_q != period_m1) begin
            cnt_d = cnt_q + CW'(1);
          end else begin
            cnt_d  = '0;
            done_d = 1'b1;
            if (!reload_q) begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign en   = en_q;
  assign cnt  = cnt_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_counter_en_sched.sv
// Bench for counter_en_sched: vector table, directed corner sequences and a
// random run checked against a time-based reference model.
module tb_counter_en_sched;

  localparam int CW = 8;
  localparam int PW = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop;
  logic [CW-1:0] cfg_period;
  logic [PW-1:0] cfg_presc;
  logic          cfg_reload;
  logic          en;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;

  counter_en_sched #(.CW(CW), .PW(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_period(cfg_period), .cfg_presc(cfg_presc), .cfg_reload(cfg_reload),
    .en(en), .cnt(cnt), .busy(busy), .done(done), .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counts run cycles since start; a strobe falls on every
  // (presc+1)-th cycle and the count is the strobe number modulo the period.
  bit m_run;
  int m_t, m_period, m_presc;
  bit m_reload;
  int x_en, x_cnt, x_busy, x_done, x_err;

  task automatic model_edge();
    int s;
    if (rst) begin
      m_run = 0; m_t = 0; m_period = 0; m_presc = 0; m_reload = 0;
      x_en = 0; x_cnt = 0; x_busy = 0; x_done = 0; x_err = 0;
    end else begin
      x_en = 0; x_done = 0; x_err = 0;
      if (!m_run) begin
        if (start && !stop) begin
          if (cfg_period != 0) begin
            m_period = cfg_period; m_presc = cfg_presc; m_reload = cfg_reload;
            m_t = 0; x_cnt = 0; x_busy = 1; m_run = 1;
          end else begin
            x_err = 1;
          end
        end
      end else if (stop) begin
        m_run = 0; x_busy = 0;
      end else begin
        m_t++;
        if (m_t % (m_presc + 1) == 0) begin
          s = m_t / (m_presc + 1);
          x_en = 1;
          x_cnt = s % m_period;
          if (x_cnt == 0) begin
            x_done = 1;
            if (!m_reload) begin
              m_run = 0; x_busy = 0;
            end
          end
        end
      end
    end
  endtask

  // driver: one clock edge, model updated with the inputs the DUT sampled
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".en"}, en, x_en);
    chk({tag, ".cnt"}, cnt, x_cnt);
    chk({tag, ".busy"}, busy, x_busy);
    chk({tag, ".done"}, done, x_done);
    chk({tag, ".err"}, err, x_err);
  endtask

  task automatic drive(input bit r, input bit sa, input bit so,
                       input int p, input int ps, input bit rl);
    rst = r; start = sa; stop = so;
    cfg_period = CW'(p); cfg_presc = PW'(ps); cfg_reload = rl;
  endtask

  typedef struct {
    bit r; bit sa; bit so; int p; int ps; bit rl;
    int e_en; int e_cnt; int e_busy; int e_done; int e_err;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int n_en, n_done, held;
    drive(1, 0, 0, 0, 0, 0);

    // reset, one-shot period 4, config error, start+stop collision
    vecs[0]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[4]  = '{0, 1, 0, 4, 0, 0,  0, 0, 1, 0, 0};
    vecs[5]  = '{0, 0, 0, 4, 0, 0,  1, 1, 1, 0, 0};
    vecs[6]  = '{0, 0, 0, 4, 0, 0,  1, 2, 1, 0, 0};
    vecs[7]  = '{0, 0, 0, 4, 0, 0,  1, 3, 1, 0, 0};
    vecs[8]  = '{0, 0, 0, 4, 0, 0,  1, 0, 0, 1, 0};
    vecs[9]  = '{0, 0, 0, 4, 0, 0,  0, 0, 0, 0, 0};
    vecs[10] = '{0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1};
    vecs[11] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[12] = '{0, 1, 1, 4, 0, 0,  0, 0, 0, 0, 0};
    vecs[13] = '{0, 0, 0, 4, 0, 0,  0, 0, 0, 0, 0};
    vecs[14] = '{0, 0, 0, 4, 0, 0,  0, 0, 0, 0, 0};

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].r, vecs[i].sa, vecs[i].so, vecs[i].p, vecs[i].ps, vecs[i].rl);
      step();
      chk($sformatf("vec%0d.en", i), en, vecs[i].e_en);
      chk($sformatf("vec%0d.cnt", i), cnt, vecs[i].e_cnt);
      chk($sformatf("vec%0d.busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d.done", i), done, vecs[i].e_done);
      chk($sformatf("vec%0d.err", i), err, vecs[i].e_err);
    end

    // periodic presc=2 period=3: 9 strobes and 3 done pulses in 27 cycles
    drive(1, 0, 0, 0, 0, 0); step();
    drive(0, 1, 0, 3, 2, 1); step(); chk_model("per_start");
    drive(0, 0, 0, 3, 2, 1);
    n_en = 0; n_done = 0;
    for (int i = 0; i < 27; i++) begin
      step();
      chk_model("per_run");
      chk("per_busy", busy, 1);
      n_en += en; n_done += done;
    end
    chk("per_en_count", n_en, 9);
    chk("per_done_count", n_done, 3);
    step();                       // t=28, not a strobe
    held = cnt;
    drive(0, 0, 1, 3, 2, 1); step(); // t=29 would not strobe either
    chk("per_stop_busy", busy, 0);
    chk("per_stop_cnt", cnt, held);
    chk("per_stop_en", en, 0);
    drive(0, 0, 0, 3, 2, 1); step(); chk_model("per_after_stop");

    // mid-run config change must not affect the shadowed period
    drive(0, 1, 0, 4, 0, 1); step(); chk_model("mid_start");
    drive(0, 0, 0, 7, 3, 0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      step(); chk_model("mid_run"); n_done += done;
    end
    chk("mid_done_count", n_done, 3);
    drive(0, 0, 1, 7, 3, 0); step(); chk("mid_stop_busy", busy, 0);

    // stop on a strobe edge with presc=1
    drive(0, 1, 0, 5, 1, 1); step();
    drive(0, 0, 0, 5, 1, 1); step();
    drive(0, 0, 1, 5, 1, 1); step();
    chk("coll_en", en, 0);
    chk("coll_cnt", cnt, 0);
    chk("coll_busy", busy, 0);
    chk_model("coll");

    // reset mid-run at cnt=2, then a fresh start
    drive(0, 1, 0, 4, 0, 1); step();
    drive(0, 0, 0, 4, 0, 1); step(); step();
    chk("rmid_cnt_before", cnt, 2);
    drive(1, 0, 0, 4, 0, 1); step();
    chk("rmid_en", en, 0); chk("rmid_cnt", cnt, 0); chk("rmid_busy", busy, 0);
    drive(0, 1, 0, 4, 1, 1); step(); chk("rmid_restart_busy", busy, 1);
    drive(0, 0, 0, 4, 1, 1); step(); chk("rmid_first_edge_en", en, 0);
    step(); chk("rmid_second_edge_en", en, 1); chk("rmid_second_edge_cnt", cnt, 1);

    // random stimulus against the model
    drive(1, 0, 0, 0, 0, 0); step(); chk_model("rnd_reset");
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 6),
            $urandom_range(0, 3), $urandom_range(0, 1));
      step();
      chk_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
